// File: rtl/unified_buffer_banked.sv
// unified_buffer_banked: row-organised SRAM shared by AXI, VPU write and SA read ports,
// with a post-reset zeroing sweep, byte-strobed AXI writes and registered 1-cycle reads.
module unified_buffer_banked #(
    parameter int  DEPTH     = 256,
    parameter int  LANE_BITS = 128,
    parameter int  AXI_DW    = 64,
    localparam int ROW_BITS  = 4 * LANE_BITS,
    localparam int AXI_AW    = $clog2(DEPTH * ROW_BITS / AXI_DW),
    localparam int LANE_AW   = $clog2(DEPTH * 4)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                axi_en,
    input  logic                axi_we,
    input  logic [AXI_AW-1:0]   axi_addr,
    input  logic [AXI_DW-1:0]   axi_wdata,
    input  logic [AXI_DW/8-1:0] axi_wstrb,
    output logic                axi_ready,
    output logic                axi_rvalid,
    output logic [AXI_DW-1:0]   axi_rdata,
    output logic                axi_err,
    input  logic                wr_en,
    output logic                wr_ready,
    input  logic [LANE_AW-1:0]  wr_addr,
    input  logic [1:0]          wr_size,
    input  logic [ROW_BITS-1:0] wr_data,
    input  logic                rd_en,
    input  logic [LANE_AW-1:0]  rd_addr,
    input  logic [1:0]          rd_size,
    output logic                rd_valid,
    output logic [ROW_BITS-1:0] rd_data
);
    localparam int CHUNKS = ROW_BITS / AXI_DW;
    localparam int RW     = $clog2(DEPTH);
    typedef enum logic {INIT, RUN} state_t;
    state_t r_state, w_state_nxt;
    logic [RW-1:0]       r_cnt;
    logic [ROW_BITS-1:0] r_mem [DEPTH];
    logic                r_axi_rvalid, r_axi_err, r_rd_valid;
    logic [AXI_DW-1:0]   r_axi_rdata;
    logic [ROW_BITS-1:0] r_rd_data;
    logic                w_run, w_axi_ok, w_wr_ok, w_rd_ok, w_we;
    logic [AXI_AW-1:0]   w_axi_row, w_axi_chunk;
    logic [RW-1:0]       w_wr_row, w_rd_row, w_wrow;
    logic [AXI_DW-1:0]   w_strb_bits;
    logic [ROW_BITS-1:0] w_axi_mask, w_axi_data, w_vpu_mask, w_vpu_data, w_wmask, w_wdata;
    logic [ROW_BITS-1:0] w_axi_rowdata, w_rd_rowdata, w_rd_lanes;
    assign w_run       = r_state == RUN;
    assign init_busy   = r_state == INIT;
    assign axi_ready   = w_run;
    assign wr_ready    = w_run && !(axi_en && axi_we);
    assign w_axi_row   = axi_addr / AXI_AW'(CHUNKS);
    assign w_axi_chunk = axi_addr % AXI_AW'(CHUNKS);
    assign w_wr_row    = wr_addr[LANE_AW-1:2];
    assign w_rd_row    = rd_addr[LANE_AW-1:2];
    // Row indices only exceed DEPTH-1 when DEPTH is not a power of two
    assign w_axi_ok    = 32'(w_axi_row) < DEPTH;
    assign w_wr_ok     = 32'(w_wr_row) < DEPTH;
    assign w_rd_ok     = 32'(w_rd_row) < DEPTH;
    for (genvar b = 0; b < AXI_DW / 8; b++) begin : g_strb
        assign w_strb_bits[b*8 +: 8] = {8{axi_wstrb[b]}};
    end
    assign w_axi_mask    = ROW_BITS'(w_strb_bits) << (32'(w_axi_chunk) * AXI_DW);
    assign w_axi_data    = ROW_BITS'(axi_wdata) << (32'(w_axi_chunk) * AXI_DW);
    assign w_axi_rowdata = r_mem[RW'(w_axi_row)];
    assign w_rd_rowdata  = r_mem[w_rd_row];
    // Per slot: which request lane position feeds it on write, and which slot feeds it on read
    for (genvar s = 0; s < 4; s++) begin : g_slot
        localparam logic [1:0] S = 2'(s);
        logic       w_wsel, w_rsel;
        logic [1:0] w_wpos, w_rslot;
        assign w_wsel = wr_size == 2'd3 || (wr_size == 2'd2 && wr_addr[1] == S[1]) ||
                        (wr_size == 2'd1 && wr_addr[1:0] == S);
        assign w_wpos = wr_size == 2'd3 ? S : wr_size == 2'd2 ? {1'b1, S[0]} : 2'd3;
        assign w_vpu_mask[s*LANE_BITS +: LANE_BITS] = {LANE_BITS{w_wsel}};
        assign w_vpu_data[s*LANE_BITS +: LANE_BITS] = LANE_BITS'(wr_data >> (32'(w_wpos) * LANE_BITS));
        assign w_rsel  = rd_size == 2'd3 || (rd_size == 2'd2 && S[1]) || (rd_size == 2'd1 && S == 2'd3);
        assign w_rslot = rd_size == 2'd3 ? S : rd_size == 2'd2 ? {rd_addr[1], S[0]} : rd_addr[1:0];
        assign w_rd_lanes[s*LANE_BITS +: LANE_BITS] =
            w_rsel ? LANE_BITS'(w_rd_rowdata >> (32'(w_rslot) * LANE_BITS)) : '0;
    end
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_wrow      = w_wr_row;
        w_wmask     = w_vpu_mask;
        w_wdata     = w_vpu_data;
        if (r_state == INIT) begin
            w_we        = 1'b1;
            w_wrow      = r_cnt;
            w_wmask     = '1;
            w_wdata     = '0;
            w_state_nxt = r_cnt == RW'(DEPTH - 1) ? RUN : INIT;
        end else if (axi_en && axi_we) begin
            w_we    = w_axi_ok;
            w_wrow  = RW'(w_axi_row);
            w_wmask = w_axi_mask;
            w_wdata = w_axi_data;
        end else begin
            w_we = wr_en && w_wr_ok;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= INIT;
        else     r_state <= w_state_nxt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_cnt        <= '0;
            r_axi_rvalid <= 1'b0;
            r_axi_err    <= 1'b0;
            r_axi_rdata  <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_cnt        <= r_state == INIT ? r_cnt + 1'b1 : '0;
            r_axi_rvalid <= w_run && axi_en && !axi_we;
            r_axi_err    <= w_run && axi_en && !w_axi_ok;
            r_axi_rdata  <= (w_run && axi_en && !axi_we && w_axi_ok) ?
                            AXI_DW'(w_axi_rowdata >> (32'(w_axi_chunk) * AXI_DW)) : '0;
            r_rd_valid   <= w_run && rd_en;
            r_rd_data    <= (w_run && rd_en && w_rd_ok) ? w_rd_lanes : '0;
        end
    // Storage has no reset; the sweep zeroes it, and reads sample old data before the write lands
    always_ff @(posedge clk)
        if (w_we) r_mem[w_wrow] <= (r_mem[w_wrow] & ~w_wmask) | (w_wdata & w_wmask);
    assign axi_rvalid = r_axi_rvalid;
    assign axi_err    = r_axi_err;
    assign axi_rdata  = r_axi_rdata;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
endmodule

// File: tb/tb_unified_buffer_banked.sv
// tb_unified_buffer_banked: directed + random checks of two buffer instances (DEPTH 256 and 200)
// driven by shared inputs and compared against a lane-level array model.
module tb_unified_buffer_banked;
    localparam int LB = 128, RB = 512, DW = 64, AW = 11, LW = 10;
    localparam logic [RB-1:0] LMASK = RB'({LB{1'b1}});
    logic clk = 1'b0, rst = 1'b1;
    logic axi_en = 1'b0, axi_we = 1'b0;
    logic [AW-1:0] axi_addr = '0;
    logic [DW-1:0] axi_wdata = '0;
    logic [7:0]    axi_wstrb = '0;
    logic wr_en = 1'b0, rd_en = 1'b0;
    logic [LW-1:0] wr_addr = '0, rd_addr = '0;
    logic [1:0]    wr_size = '0, rd_size = '0;
    logic [RB-1:0] wr_data = '0;
    logic a_init_busy, a_axi_ready, a_axi_rvalid, a_axi_err, a_wr_ready, a_rd_valid;
    logic [DW-1:0] a_axi_rdata;
    logic [RB-1:0] a_rd_data;
    logic b_init_busy, b_axi_ready, b_axi_rvalid, b_axi_err, b_wr_ready, b_rd_valid;
    logic [DW-1:0] b_axi_rdata;
    logic [RB-1:0] b_rd_data;
    logic [RB-1:0] mem [256];
    int n_pass = 0, n_total = 0;

    unified_buffer_banked u_a (
        .clk(clk), .rst(rst), .init_busy(a_init_busy),
        .axi_en(axi_en), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_ready(a_axi_ready), .axi_rvalid(a_axi_rvalid),
        .axi_rdata(a_axi_rdata), .axi_err(a_axi_err),
        .wr_en(wr_en), .wr_ready(a_wr_ready), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_size(rd_size), .rd_valid(a_rd_valid), .rd_data(a_rd_data)
    );
    unified_buffer_banked #(.DEPTH(200)) u_b (
        .clk(clk), .rst(rst), .init_busy(b_init_busy),
        .axi_en(axi_en), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_ready(b_axi_ready), .axi_rvalid(b_axi_rvalid),
        .axi_rdata(b_axi_rdata), .axi_err(b_axi_err),
        .wr_en(wr_en), .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_size(rd_size), .rd_valid(b_rd_valid), .rd_data(b_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int slot_of(input logic [1:0] size, input logic [1:0] a, input int j);
        case (size)
            2'd1:    return j == 0 ? int'(a) : -1;
            2'd2:    return j == 0 ? 2 * int'(a[1]) + 1 : j == 1 ? 2 * int'(a[1]) : -1;
            2'd3:    return 3 - j;
            default: return -1;
        endcase
    endfunction

    function automatic logic [RB-1:0] exp_lanes(input int row, input logic [1:0] size, input logic [1:0] a);
        logic [RB-1:0] r = '0;
        for (int j = 0; j < 4; j++) begin
            int s = slot_of(size, a, j);
            if (s >= 0) r |= ((mem[row] >> (s * LB)) & LMASK) << ((3 - j) * LB);
        end
        return r;
    endfunction

    task automatic model_vpu(input int addr, input logic [1:0] size, input logic [RB-1:0] d);
        int row = addr / 4;
        for (int j = 0; j < 4; j++) begin
            int s = slot_of(size, 2'(addr), j);
            if (s >= 0) mem[row] = (mem[row] & ~(LMASK << (s * LB))) | (((d >> ((3 - j) * LB)) & LMASK) << (s * LB));
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    function automatic logic [RB-1:0] rnd512();
        logic [RB-1:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[RB-33:0], $urandom()};
        return r;
    endfunction

    task automatic axi_wr(input int addr, input logic [DW-1:0] d, input logic [7:0] s);
        int row = addr / 8, ch = addr % 8;
        axi_en = 1'b1; axi_we = 1'b1; axi_addr = AW'(addr); axi_wdata = d; axi_wstrb = s;
        tick();
        axi_en = 1'b0; axi_we = 1'b0;
        for (int b = 0; b < 8; b++)
            if (s[b]) begin
                int bi = ch * 64 + b * 8;
                logic [7:0] bv = 8'(d >> (b * 8));
                mem[row] = (mem[row] & ~(RB'(8'hFF) << bi)) | (RB'(bv) << bi);
            end
        chk("axi_wr_err_a", a_axi_err, 0);
        chk("axi_wr_err_b", b_axi_err, RB'(row >= 200));
    endtask

    task automatic axi_rd(input int addr);
        int row = addr / 8, ch = addr % 8;
        logic [DW-1:0] e;
        axi_en = 1'b1; axi_we = 1'b0; axi_addr = AW'(addr);
        tick();
        axi_en = 1'b0;
        e = DW'(mem[row] >> (ch * 64));
        chk("axi_rvalid_a", a_axi_rvalid, 1);
        chk("axi_rdata_a", a_axi_rdata, e);
        chk("axi_err_a", a_axi_err, 0);
        chk("axi_rvalid_b", b_axi_rvalid, 1);
        chk("axi_rdata_b", b_axi_rdata, row < 200 ? e : '0);
        chk("axi_err_b", b_axi_err, RB'(row >= 200));
    endtask

    task automatic vpu_wr(input int addr, input logic [1:0] size, input logic [RB-1:0] d);
        int n = 0;
        wr_en = 1'b1; wr_addr = LW'(addr); wr_size = size; wr_data = d;
        #1;
        while (!a_wr_ready && n < 20) begin tick(); n++; end
        chk("vpu_wr_ready", a_wr_ready, 1);
        tick();
        wr_en = 1'b0;
        model_vpu(addr, size, d);
    endtask

    task automatic sa_rd(input int addr, input logic [1:0] size);
        int row = addr / 4;
        logic [RB-1:0] e;
        rd_en = 1'b1; rd_addr = LW'(addr); rd_size = size;
        tick();
        rd_en = 1'b0;
        e = exp_lanes(row, size, 2'(addr));
        chk("rd_valid_a", a_rd_valid, 1);
        chk("rd_data_a", a_rd_data, e);
        chk("rd_valid_b", b_rd_valid, 1);
        chk("rd_data_b", b_rd_data, row < 200 ? e : '0);
    endtask

    task automatic sweep(input int len);
        int n = 0, bad = 0;
        while (a_init_busy && n < 2 * len) begin
            if (a_rd_valid || a_axi_rvalid || a_axi_ready || a_wr_ready) bad++;
            tick();
            n++;
        end
        chk("sweep_len", n, len);
        chk("sweep_quiet", bad, 0);
        chk("sweep_no_rd_valid", a_rd_valid, 0);
        chk("run_axi_ready", a_axi_ready, 1);
    endtask

    initial begin
        logic [RB-1:0] d, v;
        int rows[8] = '{1, 2, 3, 7, 199, 200, 201, 255};
        model_clear();
        repeat (3) tick();
        chk("rst_init_busy", a_init_busy, 1);
        chk("rst_axi_ready", a_axi_ready, 0);
        chk("rst_wr_ready", a_wr_ready, 0);
        chk("rst_axi_rvalid", a_axi_rvalid, 0);
        chk("rst_axi_err", a_axi_err, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_axi_rdata", a_axi_rdata, 0);
        chk("rst_rd_data", a_rd_data, 0);
        rd_en = 1'b1; rd_addr = LW'(20); rd_size = 2'd3;
        rst = 1'b0;
        sweep(256);
        chk("b_done", b_init_busy, 0);
        tick();
        rd_en = 1'b0;
        chk("first_rd_valid", a_rd_valid, 1);
        chk("first_rd_data", a_rd_data, 0);
        // arbitration: AXI write wins for one cycle
        d = rnd512();
        wr_en = 1'b1; wr_addr = LW'(6); wr_size = 2'd2; wr_data = d;
        axi_en = 1'b1; axi_we = 1'b1; axi_addr = AW'(11'h100); axi_wdata = 64'hCAFE_F00D_1234_5678; axi_wstrb = 8'hFF;
        #1;
        chk("arb_wr_ready_lo", a_wr_ready, 0);
        tick();
        axi_en = 1'b0; axi_we = 1'b0;
        mem[32] = RB'(64'hCAFE_F00D_1234_5678);
        #1;
        chk("arb_wr_ready_hi", a_wr_ready, 1);
        tick();
        wr_en = 1'b0;
        model_vpu(6, 2'd2, d);
        sa_rd(4, 2'd3);
        chk("arb_row1", a_rd_data, {d[511:256], 256'b0});
        axi_rd(11'h100);
        // strobed AXI write
        axi_wr(9, 64'h1122334455667788, 8'h0F);
        axi_rd(9);
        chk("strobe_rdata", a_axi_rdata, 64'h0000000055667788);
        // read-first on row 2 slot 0
        v = rnd512();
        vpu_wr(8, 2'd1, v);
        wr_en = 1'b1; wr_addr = LW'(8); wr_size = 2'd1; wr_data = {{16{8'hAA}}, 384'b0};
        rd_en = 1'b1; rd_addr = LW'(8); rd_size = 2'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rf_old", a_rd_data, {v[511:384], 384'b0});
        model_vpu(8, 2'd1, {{16{8'hAA}}, 384'b0});
        sa_rd(8, 2'd1);
        chk("rf_new", a_rd_data, {{16{8'hAA}}, 384'b0});
        // size 00 read and write
        vpu_wr(12, 2'd0, rnd512());
        sa_rd(12, 2'd0);
        // out of range on the DEPTH=200 instance
        axi_rd(1600);
        axi_wr(1600, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        tick();
        chk("err_pulse_end", b_axi_err, 0);
        axi_rd(1600);
        axi_rd(0);
        sa_rd(800, 2'd3);
        // random traffic
        for (int i = 0; i < 120; i++) begin
            int r = rows[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: axi_wr(r * 8 + $urandom_range(0, 7), {$urandom(), $urandom()}, 8'($urandom()));
                1: axi_rd(r * 8 + $urandom_range(0, 7));
                2: vpu_wr(r * 4 + $urandom_range(0, 3), 2'($urandom()), rnd512());
                default: sa_rd(r * 4 + $urandom_range(0, 3), 2'($urandom()));
            endcase
        end
        // async reset while a read response is valid
        rd_en = 1'b1; rd_addr = LW'(8); rd_size = 2'd1;
        tick();
        rd_en = 1'b0;
        chk("pre_rst_valid", a_rd_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rd_valid", a_rd_valid, 0);
        chk("async_rd_data", a_rd_data, 0);
        chk("async_init_busy", a_init_busy, 1);
        chk("async_axi_ready", a_axi_ready, 0);
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("mid_sweep_busy", a_init_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", a_init_busy, 1);
        chk("mid_rst_wr_ready", a_wr_ready, 0);
        tick();
        rst = 1'b0;
        model_clear();
        sweep(256);
        sa_rd(8, 2'd1);
        sa_rd(4, 2'd3);
        axi_rd(9);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/unified_buffer_banked.md
Name: unified_buffer_banked

Overview:
- Parametrised successor to the single-array input store: one row-organised SRAM of DEPTH rows × (4 × LANE_BITS), sitting between the AXI slave and the systolic-array/VPU datapath.
- Adds byte-strobed AXI writes, a ready/valid handshake on the VPU write port, and registered 1-cycle read ports with valid flags.
- Adds a post-reset zero-initialisation sweep, replacing reset-time array loops.
- Adds out-of-range detection for non-power-of-two DEPTH.

Parameters:
- DEPTH, 256, number of rows (any value ≥ 2).
- LANE_BITS, 128, bits per lane (one 16×int8 array column set); must be a multiple of AXI_DW.
- AXI_DW, 64, AXI data width.
- Derived: ROW_BITS = 4×LANE_BITS; AXI_AW = clog2(DEPTH×ROW_BITS/AXI_DW); LANE_AW = clog2(DEPTH×4).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- init_busy  out  1  high while the zeroing sweep runs.
- axi_en  in  1  AXI access strobe.
- axi_we  in  1  1 = write, 0 = read.
- axi_addr  in  AXI_AW  AXI_DW-word address.
- axi_wdata  in  AXI_DW  write data.
- axi_wstrb  in  AXI_DW/8  byte enables.
- axi_ready  out  1  access accepted this cycle.
- axi_rvalid  out  1  read data valid.
- axi_rdata  out  AXI_DW  read data.
- axi_err  out  1  pulses with the response of an out-of-range access.
- wr_en  in  1  VPU write request.
- wr_ready  out  1  VPU write accepted.
- wr_addr  in  LANE_AW  lane-granular address: row = addr[LANE_AW-1:2], slot = addr[1:0].
- wr_size  in  2  lanes to write: 01 = 1, 10 = 2, 11 = 4, 00 = none.
- wr_data  in  4×LANE_BITS  request lanes; lane k occupies bits [(3-k)×LANE_BITS +: LANE_BITS].
- rd_en  in  1  SA/weight read request.
- rd_addr  in  LANE_AW  lane-granular address.
- rd_size  in  2  lanes to read, same encoding as wr_size.
- rd_valid  out  1  read data valid.
- rd_data  out  4×LANE_BITS  read lanes, same packing as wr_data.

Behaviour:
- Reset values: init_busy = 1; axi_ready = 0; wr_ready = 0; axi_rvalid = 0; axi_err = 0; rd_valid = 0; axi_rdata = 0; rd_data = 0.
- FSM states: INIT and RUN. Reset forces INIT with row counter = 0.
- INIT: writes zero to row[counter] each cycle and increments the counter. After row DEPTH-1 is written, moves to RUN, so init_busy is high for exactly DEPTH cycles after rst deasserts.
- INIT: axi_ready = 0 and wr_ready = 0; rd_en and axi_en are ignored and produce no valid response.
- Reset asserted mid-operation (any state): returns to INIT, clears all valids, restarts the sweep at row 0.
- RUN: axi_ready = 1; the AXI port never stalls.
- RUN: wr_ready = !(axi_en && axi_we). AXI write has priority; the VPU holds wr_en/wr_addr/wr_size/wr_data until it sees wr_en && wr_ready.
- AXI write: row = axi_addr / (ROW_BITS/AXI_DW), chunk = remainder, chunk bits [chunk×AXI_DW +: AXI_DW]. Byte b is written only if axi_wstrb[b] = 1.
- Slot/lane mapping, writes and reads:
  - Size 01: lane 0 ↔ slot addr[1:0].
  - Size 10: h = addr[1], addr[0] ignored; lane 0 ↔ slot 2h+1, lane 1 ↔ slot 2h.
  - Size 11: addr[1:0] ignored; lane j ↔ slot 3-j.
  - Slot s is row bits [s×LANE_BITS +: LANE_BITS].
- Size 00: write completes the handshake with no array change; read returns valid all-zero data.
- Read latency is 1 cycle. A request sampled at edge N gives rd_valid / axi_rvalid high for cycle N+1 with the addressed data. Unused read lanes are 0.
- When not valid, rd_data and axi_rdata are 0.
- Back-to-back reads are accepted every cycle.
- Read-first: a read of a location written at the same edge returns the pre-write data.
- A VPU write and an SA read may occur in the same cycle.
- Out of range: a row index ≥ DEPTH on any port means the write is dropped but still handshaken; a read returns valid = 1 with data 0. axi_err pulses 1 cycle with axi_rvalid for AXI reads, and 1 cycle after acceptance for AXI writes. The VPU and SA ports have no error flag.

Test Plan:
- Init sweep: release rst, hold rd_en at row 5 size 11 → init_busy high for exactly 256 cycles, no rd_valid during the sweep; first RUN read returns rd_data = 0 with rd_valid 1 cycle later.
- Strobed AXI write: write addr 0x009 with data 0x1122334455667788, wstrb = 0x0F, then read 0x009 → axi_rdata = 0x0000000055667788 with axi_rvalid 1 cycle later.
- Arbitration: VPU wr size 10 at addr 6 concurrent with an AXI write for 1 cycle → wr_ready = 0 that cycle, 1 the next. Then rd size 11 at row 1 returns slots 3/2 = VPU lanes 0/1 and slots 1/0 = 0.
- Read-first: same-edge VPU write 0xAA.. and SA read of slot 0 row 2 → first rd_data = old value; next read = 0xAA..
- Out of range with DEPTH = 200: AXI read of row 200 → axi_rvalid = 1, axi_rdata = 0, axi_err = 1; AXI write there → memory unchanged, axi_err pulses.
- Reset mid-sweep: assert rst at sweep row 100 → outputs return to reset values, and init_busy is high for a full 256 cycles after release.
